// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state and SPI mode types for the multi-mode SPI master
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} spi_state_t;
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: one-cycle tick every CLK_DIV clk cycles while en is high
// Ports: clk, rst (sync, active-high), en (counter clears when low), tick (pulse on the last count)
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && cnt_q == CW'(CLK_DIV - 1);
        cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: full-duplex SPI master with run-time CPOL/CPHA and NUM_SS active-low selects
// Ports: clk, rst (sync, active-high); start/ready/done handshake; mode={CPOL,CPHA}, ss_sel and
//        tx_data are latched on accept; rx_data updates in the done cycle; sclk/mosi/miso/ss_n pins.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NUM_SS  = 2,
    parameter int  CLK_DIV = 50,
    localparam int SW      = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [SW-1:0]     ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int            EW   = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d, ready_q, ready_d, tick;
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk (clk),
        .rst (rst),
        .en  (state_q == SETUP || state_q == XFER || state_q == HOLD),
        .tick(tick)
    );
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = mode[1];
                if (start && ready_q) begin
                    state_d    = SETUP;
                    mode_d     = spi_mode_t'(mode);
                    // CPHA=0 presents the MSB now, so the shifter is preloaded one bit ahead
                    tx_sh_d    = mode[0] ? tx_data : tx_data << 1;
                    mosi_d     = mode[0] ? mosi_q : tx_data[DATA_W-1];
                    edge_cnt_d = '0;
                    // an out-of-range ss_sel matches no index and leaves every select high
                    for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = ss_sel != SW'(i);
                end
            end
            SETUP: begin
                sclk_d = mode_q.cpol;
                if (tick) state_d = XFER;
            end
            XFER: if (tick) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
                sclk_d     = ~sclk_q;
                // odd edges lead; CPHA=0 samples on leading edges, CPHA=1 on trailing ones
                if (edge_cnt_d[0] ^ mode_q.cpha) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                else if (mode_q.cpha || edge_cnt_d != LAST) begin
                    mosi_d  = tx_sh_q[DATA_W-1];
                    tx_sh_d = tx_sh_q << 1;
                end
                if (edge_cnt_d == LAST) state_d = HOLD;
            end
            HOLD: begin
                sclk_d = mode_q.cpol;
                if (tick) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    ss_n_d    = '1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            ss_n_q     <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            edge_cnt_q <= edge_cnt_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end
    assign ready   = ready_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed checks of the SPI master against mode-matched slave models
module tb_spi_master_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       a_start, a_ready, a_done, a_sclk, a_mosi, a_miso, a_sel;
    logic [1:0] a_mode, a_ss_n;
    logic [7:0] a_tx, a_rx;
    spi_master_multi #(.DATA_W(8), .NUM_SS(2), .CLK_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .ss_sel(a_sel), .tx_data(a_tx),
        .ready(a_ready), .done(a_done), .rx_data(a_rx), .sclk(a_sclk), .mosi(a_mosi),
        .miso(a_miso), .ss_n(a_ss_n)
    );

    logic        b_start, b_ready, b_done, b_sclk, b_mosi, b_miso, b_sel;
    logic [1:0]  b_mode, b_ss_n;
    logic [15:0] b_tx, b_rx;
    spi_master_multi #(.DATA_W(16), .NUM_SS(2), .CLK_DIV(2)) dut16 (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .ss_sel(b_sel), .tx_data(b_tx),
        .ready(b_ready), .done(b_done), .rx_data(b_rx), .sclk(b_sclk), .mosi(b_mosi),
        .miso(b_miso), .ss_n(b_ss_n)
    );

    // 8-bit slave: counts sclk edges of the current transfer, shifts its word out, captures mosi
    logic [1:0] s8_mode = 2'b00;
    logic [7:0] s8_word = 8'h00;
    logic [7:0] s8_cap  = 8'h00;
    int         s8_e    = 0;
    int         s8_idx;
    logic       s8_prev = 1'b0;
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            s8_e   = 0;
            s8_cap = 8'h00;
        end else if (a_sclk !== s8_prev) begin
            s8_e++;
            if (s8_e[0] != s8_mode[0]) s8_cap = {s8_cap[6:0], a_mosi};
        end
        s8_prev = a_sclk;
        s8_idx  = (s8_e - (s8_mode[0] ? 1 : 0)) / 2;
        a_miso  = (s8_idx >= 0 && s8_idx < 8) ? s8_word[7-s8_idx] : 1'b0;
    end

    // 16-bit mode-0 slave: sends s16_words[0] then s16_words[1] on successive transfers
    logic [15:0] s16_words [2];
    logic [15:0] s16_cap  = 16'h0000;
    int          s16_e    = 0;
    int          s16_w    = 0;
    int          s16_idx;
    logic        s16_prev = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b1) s16_w = 0;
        if (b_ready === 1'b1) begin
            s16_e   = 0;
            s16_cap = 16'h0000;
        end else if (b_sclk !== s16_prev) begin
            s16_e++;
            if (s16_e[0]) s16_cap = {s16_cap[14:0], b_mosi};
        end
        s16_prev = b_sclk;
        s16_idx  = s16_e / 2;
        b_miso   = (s16_idx < 16 && s16_w < 2) ? s16_words[s16_w][15-s16_idx] : 1'b0;
        if (b_done === 1'b1) s16_w++;
    end

    int         r_dcyc, r_ndone, r_edges;
    bit         r_rdy_bad, r_ss_bad;
    logic [1:0] r_ss_mid, r_ss_done;
    logic [7:0] r_cap;
    logic       r_idle_sclk;

    // one 8-bit transfer, recording what the pins did; disturb pokes start/inputs mid-word
    task automatic run8(input logic [1:0] m, input logic s, input logic [7:0] tx,
                        input logic [7:0] sw, input bit disturb);
        s8_mode = m;
        s8_word = sw;
        a_mode  = m;
        a_sel   = s;
        a_tx    = tx;
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 r_idle_sclk = a_sclk;
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        r_dcyc    = -1;
        r_ndone   = 0;
        r_edges   = -1;
        r_rdy_bad = 1'b0;
        r_ss_bad  = 1'b0;
        r_ss_mid  = a_ss_n;
        r_ss_done = 2'bxx;
        r_cap     = 8'hxx;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (a_done === 1'b1) begin
                r_ndone++;
                if (r_dcyc < 0) begin
                    r_dcyc    = c;
                    r_ss_done = a_ss_n;
                    r_edges   = s8_e;
                    r_cap     = s8_cap;
                end
            end else if (r_dcyc < 0) begin
                if (a_ready !== 1'b0) r_rdy_bad = 1'b1;
                if (a_ss_n !== r_ss_mid) r_ss_bad = 1'b1;
            end
            if (disturb && c == 30) begin
                a_start = 1'b1;
                a_tx    = ~tx;
                a_sel   = ~s;
                a_mode  = ~m;
            end
            if (disturb && c == 31) a_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
        n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", a_done); end
        n_tests++; if (a_rx !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h exp=00", a_rx); end
        n_tests++; if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", a_sclk); end
        n_tests++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", a_mosi); end
        n_tests++; if (a_ss_n !== 2'b11) begin n_fail++; $display("FAIL reset_ss_n got=%b exp=11", a_ss_n); end
        n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready16 got=%b exp=1", b_ready); end
        rst = 1'b0;
    endtask

    task automatic test_mode0();
        run8(2'd0, 1'b0, 8'hA5, 8'h3C, 1'b0);
        n_tests++; if (r_dcyc !== 73) begin n_fail++; $display("FAIL mode0_latency got=%0d exp=73", r_dcyc); end
        n_tests++; if (a_rx !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx got=%h exp=3c", a_rx); end
        n_tests++; if (r_cap !== 8'hA5) begin n_fail++; $display("FAIL mode0_mosi got=%h exp=a5", r_cap); end
        n_tests++; if (r_edges !== 16) begin n_fail++; $display("FAIL mode0_edges got=%0d exp=16", r_edges); end
        n_tests++; if (r_idle_sclk !== 1'b0) begin n_fail++; $display("FAIL mode0_idle_sclk got=%b exp=0", r_idle_sclk); end
        n_tests++; if (r_ss_mid !== 2'b10) begin n_fail++; $display("FAIL mode0_ss_n got=%b exp=10", r_ss_mid); end
        n_tests++; if (r_ss_bad !== 1'b0) begin n_fail++; $display("FAIL mode0_ss_stable got=%b exp=0", r_ss_bad); end
        n_tests++; if (r_ss_done !== 2'b11) begin n_fail++; $display("FAIL mode0_ss_done got=%b exp=11", r_ss_done); end
        n_tests++; if (r_ndone !== 1) begin n_fail++; $display("FAIL mode0_ndone got=%0d exp=1", r_ndone); end
        n_tests++; if (r_rdy_bad !== 1'b0) begin n_fail++; $display("FAIL mode0_ready_busy got=%b exp=0", r_rdy_bad); end
        n_tests++; if (a_ss_n !== 2'b11) begin n_fail++; $display("FAIL mode0_ss_idle got=%b exp=11", a_ss_n); end
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            run8(2'(m), 1'b1, 8'hA5, 8'h3C, 1'b0);
            n_tests++; if (a_rx !== 8'h3C) begin n_fail++; $display("FAIL mode%0d_rx got=%h exp=3c", m, a_rx); end
            n_tests++; if (r_cap !== 8'hA5) begin n_fail++; $display("FAIL mode%0d_mosi got=%h exp=a5", m, r_cap); end
            n_tests++; if (r_edges !== 16) begin n_fail++; $display("FAIL mode%0d_edges got=%0d exp=16", m, r_edges); end
            n_tests++; if (r_idle_sclk !== (m >= 2)) begin n_fail++; $display("FAIL mode%0d_idle_sclk got=%b exp=%0d", m, r_idle_sclk, m >= 2); end
            n_tests++; if (r_ss_mid !== 2'b01) begin n_fail++; $display("FAIL mode%0d_ss_n got=%b exp=01", m, r_ss_mid); end
            n_tests++; if (r_dcyc !== 73) begin n_fail++; $display("FAIL mode%0d_latency got=%0d exp=73", m, r_dcyc); end
        end
    endtask

    task automatic test_busy_ignore();
        run8(2'd0, 1'b0, 8'hA5, 8'h3C, 1'b1);
        n_tests++; if (r_ndone !== 1) begin n_fail++; $display("FAIL busy_ndone got=%0d exp=1", r_ndone); end
        n_tests++; if (a_rx !== 8'h3C) begin n_fail++; $display("FAIL busy_rx got=%h exp=3c", a_rx); end
        n_tests++; if (r_cap !== 8'hA5) begin n_fail++; $display("FAIL busy_mosi got=%h exp=a5", r_cap); end
        n_tests++; if (r_ss_bad !== 1'b0) begin n_fail++; $display("FAIL busy_ss_stable got=%b exp=0", r_ss_bad); end
        n_tests++; if (r_rdy_bad !== 1'b0) begin n_fail++; $display("FAIL busy_ready got=%b exp=0", r_rdy_bad); end
        n_tests++; if (r_dcyc !== 73) begin n_fail++; $display("FAIL busy_latency got=%0d exp=73", r_dcyc); end
    endtask

    task automatic test_reset_mid();
        bit seen_done = 1'b0;
        s8_mode = 2'd0;
        s8_word = 8'h3C;
        a_mode  = 2'd0;
        a_sel   = 1'b0;
        a_tx    = 8'hA5;
        repeat (3) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int i = 0; i < 200 && s8_e != 5; i++) begin
            @(posedge clk);
            #1;
        end
        n_tests++; if (s8_e !== 5) begin n_fail++; $display("FAIL rstmid_reach_edge5 got=%0d exp=5", s8_e); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (a_ss_n !== 2'b11) begin n_fail++; $display("FAIL rstmid_ss_n got=%b exp=11", a_ss_n); end
        n_tests++; if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk got=%b exp=0", a_sclk); end
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", a_ready); end
        n_tests++; if (a_rx !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx got=%h exp=00", a_rx); end
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (a_done !== 1'b0) seen_done = 1'b1;
            @(posedge clk);
            #1;
        end
        n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got=%b exp=0", seen_done); end
        run8(2'd0, 1'b0, 8'hFF, 8'h96, 1'b0);
        n_tests++; if (a_rx !== 8'h96) begin n_fail++; $display("FAIL rstmid_next_rx got=%h exp=96", a_rx); end
        n_tests++; if (r_cap !== 8'hFF) begin n_fail++; $display("FAIL rstmid_next_mosi got=%h exp=ff", r_cap); end
        n_tests++; if (r_dcyc !== 73) begin n_fail++; $display("FAIL rstmid_next_latency got=%0d exp=73", r_dcyc); end
    endtask

    task automatic test_back_to_back();
        int          d1 = -1, d2 = -1, nd = 0, e1 = -1;
        logic [15:0] rx1 = 'x, rx2 = 'x, cap1 = 'x, cap2 = 'x;
        s16_words[0] = 16'hA55A;
        s16_words[1] = 16'h0FF0;
        b_mode = 2'd0;
        b_sel  = 1'b0;
        b_tx   = 16'h1234;
        repeat (3) @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_tx = 16'hBEEF;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (b_done === 1'b1) begin
                nd++;
                if (d1 < 0) begin
                    d1   = c;
                    rx1  = b_rx;
                    cap1 = s16_cap;
                    e1   = s16_e;
                end else if (d2 < 0) begin
                    d2      = c;
                    rx2     = b_rx;
                    cap2    = s16_cap;
                    b_start = 1'b0;
                end
            end
        end
        b_start = 1'b0;
        n_tests++; if (d1 !== 69) begin n_fail++; $display("FAIL b2b_done1 got=%0d exp=69", d1); end
        n_tests++; if (d2 !== 139) begin n_fail++; $display("FAIL b2b_done2 got=%0d exp=139", d2); end
        n_tests++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_ndone got=%0d exp=2", nd); end
        n_tests++; if (rx1 !== 16'hA55A) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=a55a", rx1); end
        n_tests++; if (rx2 !== 16'h0FF0) begin n_fail++; $display("FAIL b2b_rx2 got=%h exp=0ff0", rx2); end
        n_tests++; if (cap1 !== 16'h1234) begin n_fail++; $display("FAIL b2b_mosi1 got=%h exp=1234", cap1); end
        n_tests++; if (cap2 !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_mosi2 got=%h exp=beef", cap2); end
        n_tests++; if (e1 !== 32) begin n_fail++; $display("FAIL b2b_edges got=%0d exp=32", e1); end
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0;
        a_mode  = 2'd0;
        a_sel   = 1'b0;
        a_tx    = 8'h00;
        b_start = 1'b0;
        b_mode  = 2'd0;
        b_sel   = 1'b0;
        b_tx    = 16'h0000;
        test_reset();
        test_mode0();
        test_modes();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
